// File: rtl/gf_hit_pkg.sv
// Shared constants, DIN field layout and FSM encoding for the hit combination generator.
package gf_hit_pkg;

  localparam int HITBITS   = 10;
  localparam int NLAYERS   = 4;
  localparam int LAYBITS   = 2;
  localparam int DEPTHBITS = 3;
  localparam int DEPTH     = 1 << DEPTHBITS;

  // DIN layout, MSB first: end-of-road flag, layer ID, hit word.
  localparam int DIN_W   = 1 + LAYBITS + HITBITS;
  localparam int EOR_BIT = LAYBITS + HITBITS;
  localparam int LAY_LSB = HITBITS;
  localparam int HIT_LSB = 0;

  typedef struct packed {
    logic               eor;
    logic [LAYBITS-1:0] layer;
    logic [HITBITS-1:0] hit;
  } din_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_ENUM = 1'b1
  } state_e;

endpackage

// File: rtl/hit_layer_buf.sv
// One layer's hit buffer: append-only storage with a fill count, a full flag
// and an asynchronous read port addressed by the enumeration index.
module hit_layer_buf
  import gf_hit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [HITBITS-1:0]   wr_data,
  input  logic [DEPTHBITS-1:0] rd_idx,
  output logic [HITBITS-1:0]   rd_data,
  output logic [DEPTHBITS:0]   cnt,
  output logic                 full
);

  logic [HITBITS-1:0]   mem_q [DEPTH];
  logic [HITBITS-1:0]   mem_d [DEPTH];
  logic [DEPTHBITS:0]   cnt_q;
  logic [DEPTHBITS:0]   cnt_d;

  // The count never exceeds DEPTH, so its top bit alone marks a full buffer.
  assign full    = cnt_q[DEPTHBITS];
  assign cnt     = cnt_q;
  assign rd_data = mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wr_en && !full) begin
      mem_d[cnt_q[DEPTHBITS-1:0]] = wr_data;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hit_comb_gen.sv
// Buffers one road's hits per layer, then walks every one-hit-per-layer
// combination with an odometer, strobing each onto HIT_OUT with CE_OUT.
module hit_comb_gen
  import gf_hit_pkg::*;
(
  input  logic                       CLOCK,
  input  logic                       RESET,
  input  logic [DIN_W-1:0]           DIN,
  input  logic                       DIN_VALID,
  output logic                       HOLD,
  input  logic                       DS_HOLD,
  output logic [NLAYERS*HITBITS-1:0] HIT_OUT,
  output logic                       CE_OUT,
  output logic                       LAST_COMB,
  output logic                       EMPTY_ROAD,
  output logic                       OVERFLOW,
  output logic                       BAD_LAYER
);

  din_t                       din;
  state_e                     state_q, state_d;
  logic [DEPTHBITS-1:0]       idx_q [NLAYERS];
  logic [DEPTHBITS-1:0]       idx_d [NLAYERS];
  logic [NLAYERS*HITBITS-1:0] hit_out_q, hit_out_d;
  logic                       ce_q, ce_d;
  logic                       last_q, last_d;
  logic                       empty_q, empty_d;
  logic                       ovf_q, ovf_d;
  logic                       bad_q, bad_d;

  logic [NLAYERS-1:0]         wr_en;
  logic [NLAYERS-1:0]         full;
  logic [NLAYERS-1:0]         at_end;
  logic [DEPTHBITS:0]         cnt [NLAYERS];
  logic [HITBITS-1:0]         rd_data [NLAYERS];
  logic                       buf_clr;
  logic                       accept, hit_word, eor_word, lay_ok;
  logic                       all_filled, all_at_end, carry;

  assign din = din_t'(DIN);

  // Words are only taken while filling; anything offered during enumeration is a protocol error and is ignored.
  always_comb begin
    accept     = DIN_VALID && (state_q == ST_FILL);
    hit_word   = accept && !din.eor;
    eor_word   = accept && din.eor;
    lay_ok     = (int'(din.layer) < NLAYERS);
    wr_en      = '0;
    all_filled = 1'b1;
    at_end     = '0;
    for (int k = 0; k < NLAYERS; k++) begin
      wr_en[k]  = hit_word && lay_ok && (int'(din.layer) == k);
      at_end[k] = ({1'b0, idx_q[k]} == (cnt[k] - 1'b1));
      if (cnt[k] == '0) begin
        all_filled = 1'b0;
      end
    end
    all_at_end = &at_end;
  end

  for (genvar g = 0; g < NLAYERS; g++) begin : g_buf
    hit_layer_buf u_buf (
      .clk     (CLOCK),
      .rst     (RESET),
      .clr     (buf_clr),
      .wr_en   (wr_en[g]),
      .wr_data (din.hit),
      .rd_idx  (idx_q[g]),
      .rd_data (rd_data[g]),
      .cnt     (cnt[g]),
      .full    (full[g])
    );
  end

  // In ENUM, a registered LAST_COMB means the final combination is already out; that cycle returns to FILL.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hit_out_d = hit_out_q;
    ce_d      = 1'b0;
    last_d    = 1'b0;
    empty_d   = 1'b0;
    bad_d     = hit_word && !lay_ok;
    ovf_d     = ovf_q;
    buf_clr   = 1'b0;
    carry     = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (eor_word) begin
          ovf_d = 1'b0;
          if (all_filled) begin
            state_d = ST_ENUM;
          end else begin
            empty_d = 1'b1;
            buf_clr = 1'b1;
          end
        end else if (hit_word && lay_ok && full[din.layer]) begin
          ovf_d = 1'b1;
        end
      end

      ST_ENUM: begin
        if (last_q) begin
          state_d = ST_FILL;
          buf_clr = 1'b1;
          for (int k = 0; k < NLAYERS; k++) begin
            idx_d[k] = '0;
          end
        end else if (!DS_HOLD) begin
          ce_d   = 1'b1;
          last_d = all_at_end;
          for (int k = 0; k < NLAYERS; k++) begin
            hit_out_d[k*HITBITS +: HITBITS] = rd_data[k];
          end
          // Layer 0 is the fastest digit; a digit at its count wraps and carries.
          carry = 1'b1;
          for (int k = 0; k < NLAYERS; k++) begin
            if (carry) begin
              if (at_end[k]) begin
                idx_d[k] = '0;
              end else begin
                idx_d[k] = idx_q[k] + 1'b1;
                carry    = 1'b0;
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= ST_FILL;
      idx_q     <= '{default: '0};
      hit_out_q <= '0;
      ce_q      <= 1'b0;
      last_q    <= 1'b0;
      empty_q   <= 1'b0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hit_out_q <= hit_out_d;
      ce_q      <= ce_d;
      last_q    <= last_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
    end
  end

  assign HOLD       = (state_q == ST_ENUM);
  assign HIT_OUT    = hit_out_q;
  assign CE_OUT     = ce_q;
  assign LAST_COMB  = last_q;
  assign EMPTY_ROAD = empty_q;
  assign OVERFLOW   = ovf_q;
  assign BAD_LAYER  = bad_q;

endmodule
